// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// LOADER_CHECKSUM_EN adds the CHECK state for the trailing XOR checksum byte.
package imem_loader_pkg;

  localparam int unsigned LEN_W_DEF      = 16;
  localparam int unsigned INSTR_W        = 32;
  // First stream byte of a word lands in the most significant lane.
  localparam bit          LANE_MSB_FIRST = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
`ifdef LOADER_CHECKSUM_EN
    ,
    S_CHECK
`endif
  } state_t;

  function automatic logic is_busy(input state_t s);
    return !(s inside {S_IDLE, S_DONE, S_ERROR});
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream (valid/ready) and instruction-memory write port of the loader.
// master: stream source / memory side; slave: the loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 10
) ();
  import imem_loader_pkg::*;

  logic [7:0]         s_data;
  logic               s_valid;
  logic               s_ready;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_wdata;

  modport master (
    output s_data, s_valid,
    input  s_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  s_data, s_valid,
    output s_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted stream bytes into 32-bit instruction words.
// word_full strobes with the accept of the fourth byte of a word.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic [7:0]         din,
  input  logic               accept,
  output logic [INSTR_W-1:0] word,
  output logic               word_full
);

  logic [1:0] lane;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane <= '0;
      word <= '0;
    end else if (clear) begin
      lane <= '0;
    end else if (accept) begin
      lane <= lane + 2'd1;
      if (LANE_MSB_FIRST) word <= {word[INSTR_W-9:0], din};
      else                word <= {din, word[INSTR_W-1:8]};
    end
  end

  assign word_full = accept && (lane == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a word-count header plus big-endian words, writes imem,
// then releases the CPU reset. LOADER_CHECKSUM_EN enables the trailing checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_rst_n,
  output logic         busy,
  output logic         done,
  output logic         error
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CHECK;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t             state, nxt;
  logic [7:0]         len_hi;
  logic [LEN_W-1:0]   len, len_rx;
  logic [ADDR_W-1:0]  idx;
  logic [INSTR_W-1:0] word;
  logic               acc, last, word_full;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         csum;
`endif

  assign acc    = bus.s_valid && bus.s_ready;
  assign len_rx = LEN_W'({len_hi, bus.s_data});
  assign last   = (32'(idx) + 32'd1) == 32'(len);

  byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (state != S_DATA),
    .din       (bus.s_data),
    .accept    (acc && (state == S_DATA)),
    .word      (word),
    .word_full (word_full)
  );

  assign bus.imem_addr  = idx;
  assign bus.imem_wdata = word;

  always_comb begin
    nxt         = state;
    bus.s_ready = 1'b0;
    bus.imem_we = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        bus.s_ready = 1'b1;
        if (bus.s_valid) nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        bus.s_ready = 1'b1;
        if (bus.s_valid) begin
          if (len_rx == '0)              nxt = S_TAIL;
          else if (32'(len_rx) > DEPTH)  nxt = S_ERROR;
          else                           nxt = S_DATA;
        end
      end
      S_DATA: begin
        bus.s_ready = 1'b1;
        if (word_full) nxt = S_WRITE;
      end
      S_WRITE: begin
        bus.imem_we = 1'b1;
        nxt         = last ? S_TAIL : S_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        bus.s_ready = 1'b1;
        if (bus.s_valid) nxt = (bus.s_data == csum) ? S_DONE : S_ERROR;
      end
`endif
      default: nxt = S_IDLE;
    endcase
  end

  // Status flags and cpu_rst_n are registered from the next state so they
  // change on the same edge as the state and never glitch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_rst_n <= 1'b0;
    end else begin
      state     <= nxt;
      busy      <= is_busy(nxt);
      done      <= (nxt == S_DONE);
      error     <= (nxt == S_ERROR);
      cpu_rst_n <= (nxt == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_hi <= '0;
      len    <= '0;
      idx    <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum   <= '0;
`endif
    end else begin
      if (state == S_LEN_HI && acc) len_hi <= bus.s_data;
      if (state == S_LEN_LO && acc) begin
        len <= len_rx;
        idx <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum <= '0;
`endif
      end
      if (state == S_WRITE && !last) idx <= idx + ADDR_W'(1);
`ifdef LOADER_CHECKSUM_EN
      if (state == S_DATA && acc) csum <= csum ^ bus.s_data;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (ADDR_W=10, LEN_W=16).
// Checksum scenarios are included when LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 1 << AW;
`ifdef LOADER_CHECKSUM_EN
  localparam int unsigned CK = 1;
`else
  localparam int unsigned CK = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cpu_rst_n, busy, done, error;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned t_start = 0;
  logic [7:0]    bx;
  logic [AW-1:0] wa[$];
  logic [31:0]   wd[$];

  imem_loader_if #(.ADDR_W(AW)) bus ();

  imem_loader #(.ADDR_W(AW), .LEN_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus.slave),
    .cpu_rst_n (cpu_rst_n),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst_n && bus.imem_we) begin
      wa.push_back(bus.imem_addr);
      wd.push_back(bus.imem_wdata);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic chk_wr(input string tag, input int unsigned i,
                        input logic [31:0] ea, input logic [31:0] ed);
    logic [31:0] oa, od;
    oa = (i < wa.size()) ? 32'(wa[i]) : 32'hFFFF_FFFF;
    od = (i < wd.size()) ? wd[i]      : 32'hFFFF_FFFF;
    chk({tag, "_addr"}, oa, ea);
    chk({tag, "_data"}, od, ed);
  endtask

  task automatic chk_reset(input string tag);
    chk1({tag, "_s_ready"},   bus.s_ready, 1'b0);
    chk1({tag, "_imem_we"},   bus.imem_we, 1'b0);
    chk ({tag, "_imem_addr"}, 32'(bus.imem_addr), 32'd0);
    chk ({tag, "_imem_wdata"}, bus.imem_wdata, 32'd0);
    chk1({tag, "_cpu_rst_n"}, cpu_rst_n, 1'b0);
    chk1({tag, "_busy"},      busy, 1'b0);
    chk1({tag, "_done"},      done, 1'b0);
    chk1({tag, "_error"},     error, 1'b0);
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  task automatic pulse_start();
    start   = 1'b1;
    t_start = cyc;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned g = 0;
    bus.s_data  = b;
    bus.s_valid = 1'b1;
    while (!bus.s_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk1("send_ready", bus.s_ready, 1'b1);
    @(negedge clk);
    bx = bx ^ b;
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    bx = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic finish_stream();
`ifdef LOADER_CHECKSUM_EN
    send_byte(bx);
`endif
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_end();
    int unsigned g = 0;
    while (!(done || error) && g < 60) begin
      @(negedge clk);
      g++;
    end
    chk1("end_reached", done || error, 1'b1);
  endtask

  initial begin
    bus.s_data  = 8'h00;
    bus.s_valid = 1'b0;
    bx          = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset("rst");

    // Bytes offered while IDLE are refused.
    rst_n       = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hAA;
    repeat (3) @(negedge clk);
    chk1("idle_s_ready", bus.s_ready, 1'b0);
    chk1("idle_busy", busy, 1'b0);
    bus.s_valid = 1'b0;

    // N=2, s_valid held high.
    clear_log();
    pulse_start();
    chk1("t1_lenhi_ready", bus.s_ready, 1'b1);
    chk1("t1_busy", busy, 1'b1);
    chk1("t1_cpu_rst_n_low", cpu_rst_n, 1'b0);
    send_hdr(16'd2);
    chk1("t1_not_done_yet", done, 1'b0);
    send_word(32'h2008_0005);
    send_word(32'h8C01_0000);
    finish_stream();
    wait_end();
    chk("t1_latency", cyc - t_start - 32'd1, 32'd12 + CK);
    chk1("t1_done", done, 1'b1);
    chk1("t1_cpu_rst_n", cpu_rst_n, 1'b1);
    chk1("t1_busy_low", busy, 1'b0);
    chk1("t1_error", error, 1'b0);
    chk("t1_nwrites", 32'(wa.size()), 32'd2);
    chk_wr("t1_w0", 0, 32'd0, 32'h2008_0005);
    chk_wr("t1_w1", 1, 32'd1, 32'h8C01_0000);
    bus.s_valid = 1'b1;
    @(negedge clk);
    chk1("done_s_ready", bus.s_ready, 1'b0);
    bus.s_valid = 1'b0;

    // Restart from DONE, 3-cycle s_valid gap mid-word, stray start in DATA.
    clear_log();
    pulse_start();
    chk1("t2_cpu_rst_n_drop", cpu_rst_n, 1'b0);
    chk1("t2_done_clear", done, 1'b0);
    chk1("t2_busy", busy, 1'b1);
    send_hdr(16'd2);
    send_byte(8'h20);
    send_byte(8'h08);
    bus.s_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    send_byte(8'h00);
    send_byte(8'h05);
    send_word(32'h8C01_0000);
    finish_stream();
    wait_end();
    chk("t2_latency", cyc - t_start - 32'd1, 32'd15 + CK);
    chk1("t2_done", done, 1'b1);
    chk("t2_nwrites", 32'(wa.size()), 32'd2);
    chk_wr("t2_w0", 0, 32'd0, 32'h2008_0005);
    chk_wr("t2_w1", 1, 32'd1, 32'h8C01_0000);

    // N=0: straight to DONE, no writes.
    clear_log();
    pulse_start();
    send_hdr(16'd0);
    finish_stream();
    wait_end();
    chk1("t3_done", done, 1'b1);
    chk1("t3_error", error, 1'b0);
    chk1("t3_cpu_rst_n", cpu_rst_n, 1'b1);
    chk("t3_nwrites", 32'(wa.size()), 32'd0);

    // N=DEPTH+1: rejected.
    clear_log();
    pulse_start();
    send_hdr(16'h0401);
    bus.s_valid = 1'b0;
    wait_end();
    chk1("t4_error", error, 1'b1);
    chk1("t4_done", done, 1'b0);
    chk1("t4_cpu_rst_n", cpu_rst_n, 1'b0);
    chk1("t4_busy", busy, 1'b0);
    chk1("t4_s_ready", bus.s_ready, 1'b0);
    chk("t4_nwrites", 32'(wa.size()), 32'd0);

    // Reset after 2nd byte of word 1, then a fresh N=1 load.
    clear_log();
    pulse_start();
    chk1("t5_error_clear", error, 1'b0);
    send_hdr(16'd2);
    send_word(32'h2008_0005);
    send_byte(8'h8C);
    send_byte(8'h01);
    bus.s_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("t5_midrst");
    chk("t5_kept_writes", 32'(wa.size()), 32'd1);
    rst_n = 1'b1;
    clear_log();
    pulse_start();
    send_hdr(16'd1);
    send_word(32'hDEAD_BEEF);
    finish_stream();
    wait_end();
    chk1("t5_done", done, 1'b1);
    chk("t5_nwrites", 32'(wa.size()), 32'd1);
    chk_wr("t5_w0", 0, 32'd0, 32'hDEAD_BEEF);

    // N=DEPTH: full memory, last write at DEPTH-1, no wrap.
    clear_log();
    pulse_start();
    send_hdr(16'(DEPTH));
    for (int unsigned i = 0; i < DEPTH; i++) send_word(32'hC0DE_0000 | i);
    finish_stream();
    wait_end();
    chk1("t6_done", done, 1'b1);
    chk1("t6_error", error, 1'b0);
    chk("t6_nwrites", 32'(wa.size()), DEPTH);
    chk_wr("t6_first", 0, 32'd0, 32'hC0DE_0000);
    chk_wr("t6_last", DEPTH - 1, DEPTH - 1, 32'hC0DE_03FF);
    chk("t6_addr_hold", 32'(bus.imem_addr), DEPTH - 1);

`ifdef LOADER_CHECKSUM_EN
    // Checksum of 12 34 56 78 is 0x08.
    clear_log();
    pulse_start();
    send_hdr(16'd1);
    send_word(32'h1234_5678);
    send_byte(8'h08);
    bus.s_valid = 1'b0;
    wait_end();
    chk1("t7_ok_done", done, 1'b1);
    chk1("t7_ok_error", error, 1'b0);
    clear_log();
    pulse_start();
    send_hdr(16'd1);
    send_word(32'h1234_5678);
    send_byte(8'h09);
    bus.s_valid = 1'b0;
    wait_end();
    chk1("t7_bad_error", error, 1'b1);
    chk1("t7_bad_done", done, 1'b0);
    chk1("t7_bad_cpu_rst_n", cpu_rst_n, 1'b0);
    chk_wr("t7_bad_w0", 0, 32'd0, 32'h1234_5678);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
